// File: rtl/reg_file16_wr_pkg.sv
// Shared constants for the ARM-style register file: special register numbers and file size.
package reg_file16_wr_pkg;

  localparam logic [3:0]  RegLr    = 4'd14;
  localparam logic [3:0]  RegPc    = 4'd15;
  localparam int unsigned RegCount = 16;
  localparam int unsigned NumRd    = 3;

  // True for the one address that is backed by fetch instead of a flop.
  function automatic logic is_pc(input logic [3:0] addr);
    return addr == RegPc;
  endfunction

endpackage

// File: rtl/reg_file16_wr_if.sv
// Write/read bus of the register file; master drives addresses and data, slave returns reads.
interface reg_file16_wr_if #(
  parameter int unsigned N = 32
);
  logic         we3;
  logic [3:0]   wa3;
  logic [N-1:0] wd3;
  logic         we_lr;
  logic [N-1:0] lr_data;
  logic [3:0]   ra1;
  logic [3:0]   ra2;
  logic [3:0]   ra3;
  logic [N-1:0] r15_in;
  logic [N-1:0] rd1;
  logic [N-1:0] rd2;
  logic [N-1:0] rd3;
  logic         wr_err;

  modport master (
    output we3, wa3, wd3, we_lr, lr_data, ra1, ra2, ra3, r15_in,
    input  rd1, rd2, rd3, wr_err
  );

  modport slave (
    input  we3, wa3, wd3, we_lr, lr_data, ra1, ra2, ra3, r15_in,
    output rd1, rd2, rd3, wr_err
  );
endinterface

// File: rtl/reg_file16_wr_decoder4x16.sv
// 4-to-16 one-hot write decoder; all outputs low when disabled.
module reg_file16_wr_decoder4x16 (
  input  logic        en_i,
  input  logic [3:0]  addr_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[addr_i] = 1'b1;
  end

endmodule

// File: rtl/reg_file16_wr.sv
// 15 flop registers (R0-R14) with a link-write path into R14 and three combinational
// read ports; address 15 reads the PC supplied by fetch.
module reg_file16_wr
  import reg_file16_wr_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter bit          BYPASS = 1'b0
) (
  input logic             clk,
  input logic             reset,
  reg_file16_wr_if.slave  bus
);

  logic [RegCount-1:0] we_dec;
  logic [N-1:0]        regs_q [RegCount-1];
  logic [N-1:0]        regs_d [RegCount-1];
  logic                wr_err_q;

  reg_file16_wr_decoder4x16 u_dec (
    .en_i     (bus.we3),
    .addr_i   (bus.wa3),
    .onehot_o (we_dec)
  );

  // R14 takes the main write port in preference to the link write.
  always_comb begin
    for (int i = 0; i < RegCount - 1; i++) begin
      regs_d[i] = we_dec[i] ? bus.wd3 : regs_q[i];
    end
    if (!we_dec[RegLr] && bus.we_lr) regs_d[RegLr] = bus.lr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RegCount - 1; i++) regs_q[i] <= '0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < RegCount - 1; i++) regs_q[i] <= regs_d[i];
      wr_err_q <= we_dec[RegPc];
    end
  end

  logic [N-1:0] rmux [RegCount];
  logic [3:0]   ra   [NumRd];
  logic [N-1:0] rd   [NumRd];

  assign ra[0] = bus.ra1;
  assign ra[1] = bus.ra2;
  assign ra[2] = bus.ra3;

  always_comb begin
    for (int i = 0; i < RegCount - 1; i++) rmux[i] = regs_q[i];
    rmux[RegPc] = bus.r15_in;
  end

  // Write-through overlays the stored value; never active while reset is held.
  always_comb begin
    for (int p = 0; p < NumRd; p++) begin
      rd[p] = rmux[ra[p]];
      if (BYPASS && !reset && !is_pc(ra[p])) begin
        if (bus.we3 && bus.wa3 == ra[p]) begin
          rd[p] = bus.wd3;
        end else if (bus.we_lr && ra[p] == RegLr) begin
          rd[p] = bus.lr_data;
        end
      end
    end
  end

  assign bus.rd1    = rd[0];
  assign bus.rd2    = rd[1];
  assign bus.rd3    = rd[2];
  assign bus.wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_file16_wr.sv
// Bench for reg_file16_wr: drives a BYPASS=0 and a BYPASS=1 instance with identical stimulus.
module tb_reg_file16_wr;

  logic        clk;
  logic        reset;
  logic        we3;
  logic [3:0]  wa3;
  logic [31:0] wd3;
  logic        we_lr;
  logic [31:0] lr_data;
  logic [3:0]  ra1, ra2, ra3;
  logic [31:0] r15_in;

  int n_checks;
  int n_errs;

  logic [31:0] mdl [15];
  logic        err_exp;

  reg_file16_wr_if #(.N(32)) bus0 ();
  reg_file16_wr_if #(.N(32)) bus1 ();

  assign bus0.we3 = we3;     assign bus1.we3 = we3;
  assign bus0.wa3 = wa3;     assign bus1.wa3 = wa3;
  assign bus0.wd3 = wd3;     assign bus1.wd3 = wd3;
  assign bus0.we_lr = we_lr; assign bus1.we_lr = we_lr;
  assign bus0.lr_data = lr_data; assign bus1.lr_data = lr_data;
  assign bus0.ra1 = ra1;     assign bus1.ra1 = ra1;
  assign bus0.ra2 = ra2;     assign bus1.ra2 = ra2;
  assign bus0.ra3 = ra3;     assign bus1.ra3 = ra3;
  assign bus0.r15_in = r15_in; assign bus1.r15_in = r15_in;

  reg_file16_wr #(.N(32), .BYPASS(1'b0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  reg_file16_wr #(.N(32), .BYPASS(1'b1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, updating the reference model from the inputs sampled at that edge.
  task automatic cycle();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 15; i++) mdl[i] = '0;
      err_exp = 1'b0;
    end else begin
      if (we_lr) mdl[14] = lr_data;
      if (we3 && wa3 != 4'd15) mdl[wa3] = wd3;
      err_exp = we3 && (wa3 == 4'd15);
    end
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input bit byp, input logic [3:0] a);
    if (a == 4'd15) return r15_in;
    if (byp && !reset) begin
      if (we3 && wa3 == a) return wd3;
      if (we_lr && a == 4'd14 && !(we3 && wa3 == 4'd14)) return lr_data;
    end
    return mdl[a];
  endfunction

  initial begin
    n_checks = 0;
    n_errs   = 0;
    err_exp  = 1'b0;
    for (int i = 0; i < 15; i++) mdl[i] = '0;
    reset = 1'b1; we3 = 1'b0; wa3 = '0; wd3 = '0; we_lr = 1'b0; lr_data = '0;
    ra1 = '0; ra2 = '0; ra3 = '0; r15_in = 32'h0000_0108;

    // 1: reset state
    repeat (2) cycle();
    reset = 1'b0;
    check("rst_wr_err", {31'd0, bus0.wr_err}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i);
      ra2 = 4'd15;
      #1;
      check("rst_rd1_b0", bus0.rd1, 32'd0);
      check("rst_rd1_b1", bus1.rd1, 32'd0);
    end
    check("rst_pc_rd2", bus0.rd2, 32'h0000_0108);

    // 2: write latency and same-cycle bypass
    we3 = 1'b1; wa3 = 4'd3; wd3 = 32'hDEAD_BEEF; ra2 = 4'd3;
    #1;
    check("byp0_same", bus0.rd2, 32'd0);
    check("byp1_same", bus1.rd2, 32'hDEAD_BEEF);
    cycle();
    we3 = 1'b0; ra1 = 4'd3;
    #1;
    check("wr3_b0", bus0.rd1, 32'hDEAD_BEEF);
    check("wr3_b1", bus1.rd1, 32'hDEAD_BEEF);

    // 3: we3 vs link write on R14, then both on separate registers
    we3 = 1'b1; wa3 = 4'd14; wd3 = 32'h11; we_lr = 1'b1; lr_data = 32'h22; ra1 = 4'd14;
    #1;
    check("lr_byp_we3_wins", bus1.rd1, 32'h11);
    cycle();
    we3 = 1'b0; we_lr = 1'b0;
    #1;
    check("lr_r14_we3", bus0.rd1, 32'h11);
    we3 = 1'b1; wa3 = 4'd5; wd3 = 32'h11; we_lr = 1'b1; lr_data = 32'h22;
    #1;
    check("lr_byp_link", bus1.rd1, 32'h22);
    cycle();
    we3 = 1'b0; we_lr = 1'b0; ra1 = 4'd5; ra2 = 4'd14;
    #1;
    check("both_r5", bus0.rd1, 32'h11);
    check("both_r14", bus0.rd2, 32'h22);

    // 4: write attempt to the PC
    we3 = 1'b1; wa3 = 4'd15; wd3 = 32'hFFFF_FFFF; ra3 = 4'd15; ra1 = 4'd3;
    #1;
    check("pc_rd3_b0", bus0.rd3, 32'h0000_0108);
    check("pc_rd3_b1", bus1.rd3, 32'h0000_0108);
    cycle();
    we3 = 1'b0;
    #1;
    check("pc_err_set", {31'd0, bus0.wr_err}, 32'd1);
    check("pc_err_set_b1", {31'd0, bus1.wr_err}, 32'd1);
    check("pc_r3_kept", bus0.rd1, 32'hDEAD_BEEF);
    check("pc_r14_kept", bus0.rd2, 32'h22);
    check("pc_rd3_after", bus0.rd3, 32'h0000_0108);
    cycle();
    check("pc_err_clr", {31'd0, bus0.wr_err}, 32'd0);

    // 5: fill, then reset with a concurrent write
    for (int i = 0; i < 15; i++) begin
      we3 = 1'b1; wa3 = 4'(i); wd3 = 32'h100 + 32'(i);
      cycle();
    end
    we3 = 1'b0; ra1 = 4'd7; ra2 = 4'd0; ra3 = 4'd14;
    #1;
    check("fill_r7", bus0.rd1, 32'h107);
    check("fill_r0", bus0.rd2, 32'h100);
    check("fill_r14", bus0.rd3, 32'h10E);
    reset = 1'b1; we3 = 1'b1; wa3 = 4'd7; wd3 = 32'hFFFF;
    #1;
    check("rst_byp_off", bus1.rd1, 32'h107);
    cycle();
    reset = 1'b0; we3 = 1'b0;
    #1;
    check("rst2_wr_err", {31'd0, bus0.wr_err}, 32'd0);
    for (int i = 0; i < 15; i++) begin
      ra1 = 4'(i);
      #1;
      check("rst2_b0", bus0.rd1, 32'd0);
      check("rst2_b1", bus1.rd1, 32'd0);
    end

    // 6: random traffic against the model
    for (int c = 0; c < 1000; c++) begin
      reset   = ($urandom_range(0, 31) == 0);
      we3     = $urandom_range(0, 1) == 1;
      wa3     = 4'($urandom_range(0, 15));
      wd3     = $urandom;
      we_lr   = $urandom_range(0, 3) == 0;
      lr_data = $urandom;
      ra1     = 4'($urandom_range(0, 15));
      ra2     = ($urandom_range(0, 1) == 1) ? wa3 : 4'($urandom_range(0, 15));
      ra3     = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
      r15_in  = $urandom;
      #1;
      check("rnd_rd1_b0", bus0.rd1, exp_rd(1'b0, ra1));
      check("rnd_rd2_b0", bus0.rd2, exp_rd(1'b0, ra2));
      check("rnd_rd3_b0", bus0.rd3, exp_rd(1'b0, ra3));
      check("rnd_rd1_b1", bus1.rd1, exp_rd(1'b1, ra1));
      check("rnd_rd2_b1", bus1.rd2, exp_rd(1'b1, ra2));
      check("rnd_rd3_b1", bus1.rd3, exp_rd(1'b1, ra3));
      cycle();
      check("rnd_err_b0", {31'd0, bus0.wr_err}, {31'd0, err_exp});
      check("rnd_err_b1", {31'd0, bus1.wr_err}, {31'd0, err_exp});
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
